// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_if
// Description : Bundle of decode-stage signals: IF/ID inputs, write-back and
//               EX hazard inputs, hazard-control and ID/EX register outputs.
// Revision    : 1.0  initial release
// ============================================================================
interface id_stage_if;
    logic [15:0] instIn;
    logic [15:0] pcAddIn;
    logic        wbWrite;
    logic [3:0]  wbReg;
    logic [15:0] wbData;
    logic        exMemRead;
    logic [3:0]  exRd;

    logic        pcWrite;
    logic        IFID_enable;
    logic        flush;
    logic        sel;
    logic [15:0] branchtoPC;
    logic [15:0] idexA;
    logic [15:0] idexB;
    logic [15:0] idexImm;
    logic [3:0]  idexRd;
    logic [2:0]  idexAluOp;
    logic        idexRegWrite;
    logic        idexMemRead;
    logic        idexMemWrite;
    logic        halted;

    // Environment side: drives the pipeline inputs, observes decode results.
    modport master (
        output instIn, pcAddIn, wbWrite, wbReg, wbData, exMemRead, exRd,
        input  pcWrite, IFID_enable, flush, sel, branchtoPC,
               idexA, idexB, idexImm, idexRd, idexAluOp,
               idexRegWrite, idexMemRead, idexMemWrite, halted
    );

    // Decode-stage side.
    modport slave (
        input  instIn, pcAddIn, wbWrite, wbReg, wbData, exMemRead, exRd,
        output pcWrite, IFID_enable, flush, sel, branchtoPC,
               idexA, idexB, idexImm, idexRd, idexAluOp,
               idexRegWrite, idexMemRead, idexMemWrite, halted
    );
endinterface
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : Instruction decode stage: register file with write-back
//               bypass, load-use hazard stall, branch/jump resolution in ID,
//               HALT handling and the ID/EX pipeline register.
// Revision    : 1.0  initial release
// ============================================================================
module id_stage #(
    parameter int BRANCH_SHIFT = 1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    id_stage_if.slave  bus
);
    localparam logic [3:0] C_OP_ADD  = 4'h1;
    localparam logic [3:0] C_OP_SUB  = 4'h2;
    localparam logic [3:0] C_OP_AND  = 4'h3;
    localparam logic [3:0] C_OP_OR   = 4'h4;
    localparam logic [3:0] C_OP_LW   = 4'h8;
    localparam logic [3:0] C_OP_SW   = 4'h9;
    localparam logic [3:0] C_OP_BEQ  = 4'hA;
    localparam logic [3:0] C_OP_BNE  = 4'hB;
    localparam logic [3:0] C_OP_JMP  = 4'hC;
    localparam logic [3:0] C_OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] rf_q [16];

    // Returns 0 for R0, the write-back data when it targets the same register
    // this cycle, otherwise the stored value.
    function automatic logic [15:0] read_port(input logic [3:0]  addr,
                                              input logic [15:0] stored,
                                              input logic        we,
                                              input logic [3:0]  wa,
                                              input logic [15:0] wd);
        if (addr == 4'd0)
            return 16'd0;
        else if (we && (wa == addr))
            return wd;
        else
            return stored;
    endfunction

    logic [3:0]  w_op, w_rd, w_rs, w_rt;
    logic [15:0] w_rd_val, w_rs_val, w_rt_val;
    logic        w_is_alu, w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_is_jmp;
    logic        w_use_rs, w_use_rt, w_use_rd;
    logic        w_hazard, w_taken, w_issue;
    logic [15:0] w_imm_ext, w_off_ext, w_target;
    logic [2:0]  w_alu_op;

    assign w_op = bus.instIn[15:12];
    assign w_rd = bus.instIn[11:8];
    assign w_rs = bus.instIn[7:4];
    assign w_rt = bus.instIn[3:0];

    assign w_rd_val = read_port(w_rd, rf_q[w_rd], bus.wbWrite, bus.wbReg, bus.wbData);
    assign w_rs_val = read_port(w_rs, rf_q[w_rs], bus.wbWrite, bus.wbReg, bus.wbData);
    assign w_rt_val = read_port(w_rt, rf_q[w_rt], bus.wbWrite, bus.wbReg, bus.wbData);

    assign w_is_alu = (w_op == C_OP_ADD) || (w_op == C_OP_SUB) ||
                      (w_op == C_OP_AND) || (w_op == C_OP_OR);
    assign w_is_lw  = (w_op == C_OP_LW);
    assign w_is_sw  = (w_op == C_OP_SW);
    assign w_is_beq = (w_op == C_OP_BEQ);
    assign w_is_bne = (w_op == C_OP_BNE);
    assign w_is_jmp = (w_op == C_OP_JMP);

    // Registers actually read by the instruction; NOP/JMP/HALT read none.
    assign w_use_rs = w_is_alu || w_is_lw || w_is_sw || w_is_beq || w_is_bne;
    assign w_use_rt = w_is_alu;
    assign w_use_rd = w_is_sw || w_is_beq || w_is_bne;

    // Load-use check only in RUN, so a held instruction stalls exactly once.
    assign w_hazard = (state_q == RUN) && bus.exMemRead && (bus.exRd != 4'd0) &&
                      ((w_use_rs && (bus.exRd == w_rs)) ||
                       (w_use_rt && (bus.exRd == w_rt)) ||
                       (w_use_rd && (bus.exRd == w_rd)));

    assign w_taken = w_is_jmp ||
                     (w_is_beq && (w_rd_val == w_rs_val)) ||
                     (w_is_bne && (w_rd_val != w_rs_val));

    assign w_imm_ext = {{12{bus.instIn[3]}}, bus.instIn[3:0]};
    assign w_off_ext = w_is_jmp ? {{4{bus.instIn[11]}}, bus.instIn[11:0]} : w_imm_ext;
    assign w_target  = bus.pcAddIn + (w_off_ext << BRANCH_SHIFT);

    assign w_alu_op = (w_op == C_OP_SUB) ? 3'b001 :
                      (w_op == C_OP_AND) ? 3'b010 :
                      (w_op == C_OP_OR)  ? 3'b011 : 3'b000;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // Next state and hazard-control outputs; reset forces the free-running values.
    always_comb begin
        state_d         = state_q;
        bus.pcWrite     = 1'b1;
        bus.IFID_enable = 1'b1;
        bus.flush       = 1'b0;
        bus.sel         = 1'b0;
        w_issue         = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (w_hazard) begin
                        state_d         = STALL;
                        bus.pcWrite     = 1'b0;
                        bus.IFID_enable = 1'b0;
                    end else begin
                        w_issue   = w_is_alu || w_is_lw || w_is_sw;
                        bus.sel   = w_taken;
                        bus.flush = w_taken;
                        if (w_op == C_OP_HALT)
                            state_d = HALT;
                    end
                end
                STALL: begin
                    state_d   = RUN;
                    w_issue   = w_is_alu || w_is_lw || w_is_sw;
                    bus.sel   = w_taken;
                    bus.flush = w_taken;
                end
                HALT: begin
                    bus.pcWrite     = 1'b0;
                    bus.IFID_enable = 1'b0;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign bus.branchtoPC = w_target;
    assign bus.halted     = (state_q == HALT);

    // Register file: cleared by reset, R0 never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                rf_q[i] <= 16'd0;
        end else if (bus.wbWrite && (bus.wbReg != 4'd0)) begin
            rf_q[bus.wbReg] <= bus.wbData;
        end
    end

    logic [15:0] idexA_q, idexB_q, idexImm_q;
    logic [3:0]  idexRd_q;
    logic [2:0]  idexAluOp_q;
    logic        idexRegWrite_q, idexMemRead_q, idexMemWrite_q;

    // ID/EX register: issued instruction or an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || !w_issue) begin
            idexA_q        <= 16'd0;
            idexB_q        <= 16'd0;
            idexImm_q      <= 16'd0;
            idexRd_q       <= 4'd0;
            idexAluOp_q    <= 3'd0;
            idexRegWrite_q <= 1'b0;
            idexMemRead_q  <= 1'b0;
            idexMemWrite_q <= 1'b0;
        end else begin
            idexA_q        <= w_rs_val;
            idexB_q        <= w_is_sw ? w_rd_val : w_rt_val;
            idexImm_q      <= w_imm_ext;
            idexRd_q       <= w_rd;
            idexAluOp_q    <= w_alu_op;
            idexRegWrite_q <= w_is_alu || w_is_lw;
            idexMemRead_q  <= w_is_lw;
            idexMemWrite_q <= w_is_sw;
        end
    end

    assign bus.idexA        = idexA_q;
    assign bus.idexB        = idexB_q;
    assign bus.idexImm      = idexImm_q;
    assign bus.idexRd       = idexRd_q;
    assign bus.idexAluOp    = idexAluOp_q;
    assign bus.idexRegWrite = idexRegWrite_q;
    assign bus.idexMemRead  = idexMemRead_q;
    assign bus.idexMemWrite = idexMemWrite_q;
endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage
// Description : Self-checking bench for id_stage: directed vector table plus
//               randomized run against a behavioural reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_id_stage;
    localparam int BRANCH_SHIFT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_if bus ();
    id_stage #(.BRANCH_SHIFT(BRANCH_SHIFT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic [15:0] inst, input logic [15:0] pc,
                         input logic wbw, input logic [3:0] wbr, input logic [15:0] wbd,
                         input logic exmr, input logic [3:0] exrd);
        rst           = r;
        bus.instIn    = inst;
        bus.pcAddIn   = pc;
        bus.wbWrite   = wbw;
        bus.wbReg     = wbr;
        bus.wbData    = wbd;
        bus.exMemRead = exmr;
        bus.exRd      = exrd;
    endtask

    function automatic logic [3:0] ctl_now();
        return {bus.pcWrite, bus.IFID_enable, bus.flush, bus.sel};
    endfunction

    // Directed vectors: one clock per row; ID/EX fields checked after the edge.
    typedef struct {
        logic        r;
        logic [15:0] inst, pc;
        logic        wbw;
        logic [3:0]  wbr;
        logic [15:0] wbd;
        logic        exmr;
        logic [3:0]  exrd;
        logic [3:0]  ctl;     // {pcWrite, IFID_enable, flush, sel}
        int          halt;    // -1: not checked
        int          tgt;     // -1: not checked
        logic [15:0] a, b, imm;
        logic [2:0]  aop;
        logic [3:0]  erd;
        logic [2:0]  ectl;    // {RegWrite, MemRead, MemWrite}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [15:0] inst, logic [15:0] pc, logic wbw,
                                logic [3:0] wbr, logic [15:0] wbd, logic exmr, logic [3:0] exrd,
                                logic [3:0] ctl, int halt, int tgt, logic [15:0] a, logic [15:0] b,
                                logic [15:0] imm, logic [2:0] aop, logic [3:0] erd, logic [2:0] ectl);
        vec_t v;
        v.r = r; v.inst = inst; v.pc = pc; v.wbw = wbw; v.wbr = wbr; v.wbd = wbd;
        v.exmr = exmr; v.exrd = exrd; v.ctl = ctl; v.halt = halt; v.tgt = tgt;
        v.a = a; v.b = b; v.imm = imm; v.aop = aop; v.erd = erd; v.ectl = ectl;
        return v;
    endfunction

    task automatic check_idex(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] imm, input logic [2:0] aop, input logic [3:0] erd,
                              input logic [2:0] ectl);
        check({tag, ".idexA"}, bus.idexA, a);
        check({tag, ".idexB"}, bus.idexB, b);
        check({tag, ".idexImm"}, bus.idexImm, imm);
        check({tag, ".idexAluOp"}, bus.idexAluOp, aop);
        check({tag, ".idexRd"}, bus.idexRd, erd);
        check({tag, ".idexCtl"}, {bus.idexRegWrite, bus.idexMemRead, bus.idexMemWrite}, ectl);
    endtask

    // Reference model state
    logic [15:0] m_rf [16];
    bit          m_halted;
    bit          m_stalled;

    function automatic logic [15:0] m_read(input logic [3:0] a, input logic wbw,
                                           input logic [3:0] wbr, input logic [15:0] wbd);
        if (a == 0) return 16'd0;
        if (wbw && wbr == a) return wbd;
        return m_rf[a];
    endfunction

    function automatic int sext(input int val, input int bits);
        return (val >= (1 << (bits - 1))) ? val - (1 << bits) : val;
    endfunction

    initial begin
        logic        r, wbw, exmr, haz, taken, issue;
        logic [15:0] inst, pc, wbd, prev_inst, va, vb, vimm, tgt;
        logic [3:0]  wbr, exrd, ectl4;
        logic [2:0]  eaop, ectl3;
        int          op, opsel;
        int          srcs[$];

        apply(1'b1, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);

        //          r  inst     pc       wbw wbr  wbd      exmr exrd ctl      halt tgt        A        B        imm      aop     rd    ectl
        tbl.push_back(mk(1, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1100, -1, -1,       16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 4'h1, 16'h0005, 0, 4'h0, 4'b1100,  0, -1,       16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 4'h2, 16'h0003, 0, 4'h0, 4'b1100,  0, -1,       16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'h1312, 16'h0000, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1100,  0, -1,       16'h5,   16'h3,   16'h2,   3'b000, 4'h3, 3'b100));
        tbl.push_back(mk(0, 16'h1312, 16'h0000, 0, 4'h0, 16'h0000, 1, 4'h1, 4'b0000,  0, -1,       16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'h1312, 16'h0000, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1100,  0, -1,       16'h5,   16'h3,   16'h2,   3'b000, 4'h3, 3'b100));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 4'h1, 16'h0007, 0, 4'h0, 4'b1100,  0, -1,       16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 4'h2, 16'h0007, 0, 4'h0, 4'b1100,  0, -1,       16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'hA12E, 16'h0010, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1111,  0, 'h000C,   16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'hB12E, 16'h0010, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1100,  0, -1,       16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'hC7FF, 16'hFFFE, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1111,  0, 'h0FFC,   16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'h1500, 16'h0000, 1, 4'h0, 16'hFFFF, 0, 4'h0, 4'b1100,  0, -1,       16'h0,   16'h0,   16'h0,   3'b000, 4'h5, 3'b100));
        tbl.push_back(mk(0, 16'h1640, 16'h0000, 1, 4'h4, 16'h1234, 0, 4'h0, 4'b1100,  0, -1,       16'h1234,16'h0,   16'h0,   3'b000, 4'h6, 3'b100));
        tbl.push_back(mk(0, 16'h1640, 16'h0000, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1100,  0, -1,       16'h1234,16'h0,   16'h0,   3'b000, 4'h6, 3'b100));
        tbl.push_back(mk(0, 16'h2412, 16'h0000, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1100,  0, -1,       16'h7,   16'h7,   16'h2,   3'b001, 4'h4, 3'b100));
        tbl.push_back(mk(0, 16'h8517, 16'h0000, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1100,  0, -1,       16'h7,   16'h0,   16'h7,   3'b000, 4'h5, 3'b110));
        tbl.push_back(mk(0, 16'hA12E, 16'h0010, 0, 4'h0, 16'h0000, 1, 4'h2, 4'b0000,  0, -1,       16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'hA12E, 16'h0010, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1111,  0, 'h000C,   16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'hF000, 16'h0000, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1100,  0, -1,       16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'h1312, 16'h0000, 1, 4'h7, 16'h0009, 0, 4'h0, 4'b0000,  1, -1,       16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(1, 16'hF000, 16'h0000, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1100,  1, -1,       16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'h1127, 16'h0000, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1100,  0, -1,       16'h0,   16'h0,   16'h7,   3'b000, 4'h1, 3'b100));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 4'h3, 16'hAAAA, 0, 4'h0, 4'b1100,  0, -1,       16'h0,   16'h0,   16'h0,   3'b000, 4'h0, 3'b000));
        tbl.push_back(mk(0, 16'h9320, 16'h0000, 0, 4'h0, 16'h0000, 0, 4'h0, 4'b1100,  0, -1,       16'h0,   16'hAAAA,16'h0,   3'b000, 4'h3, 3'b001));

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply(tbl[i].r, tbl[i].inst, tbl[i].pc, tbl[i].wbw, tbl[i].wbr, tbl[i].wbd,
                  tbl[i].exmr, tbl[i].exrd);
            #3;
            check({tag, ".ctl"}, ctl_now(), tbl[i].ctl);
            if (tbl[i].halt >= 0) check({tag, ".halted"}, bus.halted, tbl[i].halt[0]);
            if (tbl[i].tgt >= 0)  check({tag, ".branchtoPC"}, bus.branchtoPC, tbl[i].tgt[15:0]);
            @(posedge clk); #1;
            check_idex(tag, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].aop, tbl[i].erd, tbl[i].ectl);
        end

        // Randomized run against the reference model, starting from reset.
        for (int k = 0; k < 16; k++) m_rf[k] = 16'd0;
        m_halted  = 1'b0;
        m_stalled = 1'b0;
        apply(1'b1, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
        @(posedge clk); #1;
        prev_inst = 16'h0000;

        for (int n = 0; n < 1500; n++) begin
            if (m_stalled) begin
                inst = prev_inst;   // IF/ID held during the stall
                exmr = 1'b0;        // bubble now in EX
            end else begin
                opsel = $urandom_range(0, 12);
                case (opsel)
                    0: op = 0;  1: op = 1;  2: op = 2;  3: op = 3;  4: op = 4;
                    5: op = 8;  6: op = 9;  7: op = 10; 8: op = 11; 9: op = 12;
                    10: op = 5; 11: op = 13;
                    default: op = ($urandom_range(0, 3) == 0) ? 15 : 1;
                endcase
                inst = {op[3:0], 1'b0, 3'($urandom_range(0, 7)), 1'b0, 3'($urandom_range(0, 7)),
                        4'($urandom_range(0, 15))};
                if (op == 12) inst[11:0] = 12'($urandom);
                exmr = ($urandom_range(0, 2) == 0);
            end
            case ($urandom_range(0, 4))
                0: exrd = inst[11:8];
                1: exrd = inst[7:4];
                2: exrd = inst[3:0];
                3: exrd = 4'd0;
                default: exrd = 4'($urandom_range(0, 15));
            endcase
            r    = m_halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 59) == 0);
            wbw  = $urandom_range(0, 1);
            wbr  = ($urandom_range(0, 1) == 0) ? inst[7:4] : 4'($urandom_range(0, 7));
            wbd  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            pc   = 16'($urandom);
            apply(r, inst, pc, wbw, wbr, wbd, exmr, exrd);
            prev_inst = inst;

            // Model: what the rules say this instruction should do this cycle.
            op = int'(inst[15:12]);
            srcs.delete();
            if (op >= 1 && op <= 4) begin srcs.push_back(inst[7:4]); srcs.push_back(inst[3:0]); end
            else if (op == 8) srcs.push_back(inst[7:4]);
            else if (op == 9 || op == 10 || op == 11) begin srcs.push_back(inst[7:4]); srcs.push_back(inst[11:8]); end
            haz = 1'b0;
            if (!r && !m_halted && !m_stalled && exmr && exrd != 0)
                foreach (srcs[s]) if (srcs[s] == int'(exrd)) haz = 1'b1;
            va = m_read(inst[7:4], wbw, wbr, wbd);
            taken = (op == 12) ||
                    (op == 10 && m_read(inst[11:8], wbw, wbr, wbd) == va) ||
                    (op == 11 && m_read(inst[11:8], wbw, wbr, wbd) != va);
            if (r)                  ectl4 = 4'b1100;
            else if (m_halted)      ectl4 = 4'b0000;
            else if (haz)           ectl4 = 4'b0000;
            else if (taken)         ectl4 = 4'b1111;
            else                    ectl4 = 4'b1100;
            tgt = 16'((int'(pc) + ((op == 12) ? sext(int'(inst[11:0]), 12) : sext(int'(inst[3:0]), 4))
                       * (1 << BRANCH_SHIFT)) & 'hFFFF);

            #3;
            check("rnd.ctl", ctl_now(), ectl4);
            check("rnd.halted", bus.halted, m_halted);
            if (op >= 10 && op <= 12) check("rnd.branchtoPC", bus.branchtoPC, tgt);

            issue = !r && !m_halted && !haz && ((op >= 1 && op <= 4) || op == 8 || op == 9);
            if (issue) begin
                vb    = (op == 9) ? m_read(inst[11:8], wbw, wbr, wbd) : m_read(inst[3:0], wbw, wbr, wbd);
                vimm  = 16'(sext(int'(inst[3:0]), 4) & 'hFFFF);
                eaop  = (op == 2) ? 3'd1 : (op == 3) ? 3'd2 : (op == 4) ? 3'd3 : 3'd0;
                ectl3 = {((op >= 1 && op <= 4) || op == 8), (op == 8), (op == 9)};
            end else begin
                va = 16'd0; vb = 16'd0; vimm = 16'd0; eaop = 3'd0; ectl3 = 3'd0;
            end

            @(posedge clk); #1;
            check_idex("rnd", va, vb, vimm, eaop, issue ? inst[11:8] : 4'd0, ectl3);

            if (r) begin
                for (int k = 0; k < 16; k++) m_rf[k] = 16'd0;
                m_halted  = 1'b0;
                m_stalled = 1'b0;
            end else begin
                if (wbw && wbr != 0) m_rf[wbr] = wbd;
                if (!m_halted && !haz && op == 15) m_halted = 1'b1;
                m_stalled = haz;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
